// File: rtl/fifo_rx_credit_if.sv
// fifo_rx_credit_if
//   Bundles the receive-side FIFO write path, host read path and FCT credit
//   handshake of fifo_rx_credit.
//   master : driven by the environment (decoder, host, transmitter, link FSM)
//   slave  : the FIFO itself
//   Signals: wr_en/data_in (N-char write), rd_en/data_out/rd_valid (host read),
//   fct_req/fct_ack (FCT handshake), credit_clear (link reset),
//   f_full/f_empty/counter/credit/overflow_credit_error (status).
interface fifo_rx_credit_if #(
  parameter int DWIDTH = 9,
  parameter int AWIDTH = 6
);
  logic              wr_en;
  logic [DWIDTH-1:0] data_in;
  logic              rd_en;
  logic [DWIDTH-1:0] data_out;
  logic              rd_valid;
  logic              fct_ack;
  logic              credit_clear;
  logic              fct_req;
  logic              f_full;
  logic              f_empty;
  logic              overflow_credit_error;
  logic [AWIDTH:0]   counter;
  logic [AWIDTH:0]   credit;

  modport master (
    output wr_en, data_in, rd_en, fct_ack, credit_clear,
    input  data_out, rd_valid, fct_req, f_full, f_empty,
           overflow_credit_error, counter, credit
  );

  modport slave (
    input  wr_en, data_in, rd_en, fct_ack, credit_clear,
    output data_out, rd_valid, fct_req, f_full, f_empty,
           overflow_credit_error, counter, credit
  );
endinterface

// File: rtl/fifo_rx_credit.sv
// fifo_rx_credit
//   SpaceWire receive FIFO with flow-control credit accounting. Buffers
//   N-chars from the decoder, tracks credit outstanding at the far-end
//   transmitter and requests an FCT whenever space for another FCT_SIZE
//   characters can be promised. Credit violations are sticky.
//   Ports:
//     clock  : rising-edge clock
//     reset  : asynchronous active-low reset
//     bus    : fifo_rx_credit_if.slave (write, read, FCT handshake, status)
module fifo_rx_credit #(
  parameter int DWIDTH     = 9,
  parameter int AWIDTH     = 6,
  parameter int FCT_SIZE   = 8,
  parameter int MAX_CREDIT = 56
) (
  input  logic            clock,
  input  logic            reset,
  fifo_rx_credit_if.slave bus
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam int CW    = AWIDTH + 1;
  localparam int SW    = CW + 2;

  localparam logic signed [SW-1:0] DEPTH_S = SW'(DEPTH);
  localparam logic signed [SW-1:0] FCT_S   = SW'(FCT_SIZE);
  localparam logic signed [SW-1:0] MAXC_S  = SW'(MAX_CREDIT);
  localparam logic signed [SW-1:0] ONE_S   = SW'(1);
  localparam logic signed [SW-1:0] ZERO_S  = '0;

  // Zero-extend an occupancy/credit value into the signed working width.
  function automatic logic signed [SW-1:0] to_s(input logic [CW-1:0] v);
    return $signed({2'b00, v});
  endfunction

  // Clamp a signed credit result into 0..MAX_CREDIT.
  function automatic logic [CW-1:0] sat_credit(input logic signed [SW-1:0] v);
    if (v < 0)
      return '0;
    else if (v > MAXC_S)
      return CW'(MAX_CREDIT);
    else
      return v[CW-1:0];
  endfunction

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_ptr;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     credit_q;
  logic              fct_req_q;
  logic              err_q;
  logic              init_q;
  logic [DWIDTH-1:0] rd_data_p1;
  logic              vld_p1;

  logic              full;
  logic              empty;
  logic              wr_acc;
  logic              rd_acc;
  logic              grant;
  logic              cred_underflow;
  logic              fct_cond;
  logic signed [SW-1:0] headroom;
  logic signed [SW-1:0] cred_room;
  logic signed [SW-1:0] credit_sum;

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign wr_acc = bus.wr_en && !full;
  assign rd_acc = bus.rd_en && !empty;
  assign grant  = fct_req_q && bus.fct_ack;

  // Every write consumes a credit, even a dropped one: the far end spent it.
  assign credit_sum = to_s(credit_q)
                    + (grant     ? FCT_S : ZERO_S)
                    - (bus.wr_en ? ONE_S : ZERO_S);
  // A grant on the same edge covers a write arriving at zero credit.
  assign cred_underflow = bus.wr_en && (credit_q == '0) && !grant;

  // Space not yet promised to the transmitter, and room under the ceiling.
  // init_q holds off the first request by one cycle after reset release.
  assign headroom  = DEPTH_S - to_s(count_q) - to_s(credit_q);
  assign cred_room = MAXC_S - to_s(credit_q);
  assign fct_cond  = init_q && (headroom >= FCT_S) && (cred_room >= FCT_S);

  // Storage array: data only, never reset.
  always_ff @(posedge clock) begin
    if (wr_acc)
      mem[wr_ptr] <= bus.data_in;
  end

  // Stage p0 -> p1: pointers, occupancy, read data, credit and FCT control.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      credit_q   <= '0;
      fct_req_q  <= 1'b0;
      err_q      <= 1'b0;
      init_q     <= 1'b0;
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      init_q <= 1'b1;

      if (wr_acc)
        wr_ptr <= wr_ptr + 1'b1;

      if (rd_acc) begin
        rd_ptr     <= rd_ptr + 1'b1;
        rd_data_p1 <= mem[rd_ptr];
      end
      vld_p1 <= rd_acc;

      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      if (bus.credit_clear) begin
        credit_q  <= '0;
        fct_req_q <= 1'b0;
        err_q     <= 1'b0;
      end else begin
        credit_q <= sat_credit(credit_sum);
        if (cred_underflow || (bus.wr_en && full))
          err_q <= 1'b1;
        // Request holds until acknowledged, drops on the ack edge and is
        // re-evaluated on the next edge with the updated credit.
        if (grant)
          fct_req_q <= 1'b0;
        else if (!fct_req_q)
          fct_req_q <= fct_cond;
      end
    end
  end

  assign bus.data_out              = rd_data_p1;
  assign bus.rd_valid              = vld_p1;
  assign bus.fct_req               = fct_req_q;
  assign bus.f_full                = full;
  assign bus.f_empty               = empty;
  assign bus.overflow_credit_error = err_q;
  assign bus.counter               = count_q;
  assign bus.credit                = credit_q;

endmodule
